// File: rtl/rr_enc8to3_pkg.sv
// Shared sizes, FSM state encoding and the index-to-one-hot helper for the
// 8-source round-robin bus arbiter.
package rr_enc8to3_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Bit 0 of the result is R0, matching the [0:7] bus ordering.
  function automatic logic [0:NUM_REQ-1] idx_to_oh(input logic [IDX_W-1:0] idx);
    logic [0:NUM_REQ-1] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_enc8to3_pri_enc.sv
// Rotating priority encoder: finds the first set request at or after the
// pointer, searching upward and wrapping 7->0.
module pri_enc8to3
  import rr_enc8to3_pkg::*;
(
  input  logic [0:NUM_REQ-1] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'(i_ptr + IDX_W'(k));
      if (!o_valid_c && i_req[w_cand]) begin
        o_idx_c   = w_cand;
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_enc8to3.sv
// Round-robin 8-to-3 bus arbiter with optional fixed priority for R7/PC.
// A grant is held until released; release re-arbitrates in the same cycle.
module rr_enc8to3
  import rr_enc8to3_pkg::*;
#(
  parameter int unsigned PC_PRIORITY = 0
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [0:NUM_REQ-1] Req,
  input  logic               Rel,
  output logic [IDX_W-1:0]   Gnt,
  output logic [0:NUM_REQ-1] GntOH,
  output logic               GntValid,
  output logic               RelErr
);

  localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [0:NUM_REQ-1] r_gnt_oh;
  logic               r_gnt_valid;
  logic               r_rel_err;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [IDX_W-1:0]   w_gnt_nxt;
  logic               w_gnt_valid_nxt;
  logic               w_rel_err_nxt;
  logic [IDX_W-1:0]   w_arb_ptr;
  logic [IDX_W-1:0]   w_enc_idx;
  logic               w_enc_valid;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_releasing;

  // A release in GRANT advances the pointer past the releasing source first,
  // so that source ends up lowest priority in the same-cycle re-arbitration.
  assign w_releasing = (r_state == ST_GRANT) && Rel;
  assign w_arb_ptr   = w_releasing ? IDX_W'(r_gnt + IDX_W'(1)) : r_ptr;

  pri_enc8to3 u_pri_enc (
    .i_req     (Req),
    .i_ptr     (w_arb_ptr),
    .o_idx_c   (w_enc_idx),
    .o_valid_c (w_enc_valid)
  );

  assign w_win_idx = ((PC_PRIORITY != 0) && Req[PC_IDX]) ? PC_IDX : w_enc_idx;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_rel_err_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Rel) begin
          w_rel_err_nxt = 1'b1;
        end else if (w_enc_valid) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = w_win_idx;
          w_gnt_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (Rel) begin
          w_ptr_nxt = w_arb_ptr;
          if (w_enc_valid) begin
            w_gnt_nxt = w_win_idx;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_gnt_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_oh    <= '0;
      r_gnt_valid <= 1'b0;
      r_rel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_oh    <= w_gnt_valid_nxt ? idx_to_oh(w_gnt_nxt) : '0;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_rel_err   <= w_rel_err_nxt;
    end
  end

  assign Gnt      = r_gnt;
  assign GntOH    = r_gnt_oh;
  assign GntValid = r_gnt_valid;
  assign RelErr   = r_rel_err;

endmodule

// File: tb/tb_rr_enc8to3.sv
// Directed self-checking bench for rr_enc8to3; one instance per PC_PRIORITY
// setting, both driven from the same stimulus.
module tb_rr_enc8to3;

  logic       Clock;
  logic       Resetn;
  logic [0:7] Req;
  logic       Rel;

  logic [2:0] gnt0, gnt1;
  logic [0:7] oh0, oh1;
  logic       vld0, vld1;
  logic       err0, err1;

  int unsigned n_checks;
  int unsigned n_errors;

  rr_enc8to3 #(.PC_PRIORITY(0)) u_dut0 (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Rel(Rel),
    .Gnt(gnt0), .GntOH(oh0), .GntValid(vld0), .RelErr(err0)
  );

  rr_enc8to3 #(.PC_PRIORITY(1)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Rel(Rel),
    .Gnt(gnt1), .GntOH(oh1), .GntValid(vld1), .RelErr(err1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [2:0] alt_exp [4];
    n_checks = 0;
    n_errors = 0;
    Resetn = 1'b0;
    Req    = 8'b00000000;
    Rel    = 1'b0;
    cyc();
    cyc();

    chk("rst_gnt",   32'(gnt0), 32'(3'b000));
    chk("rst_oh",    32'(oh0),  32'(8'b00000000));
    chk("rst_vld",   32'(vld0), 32'(1'b0));
    chk("rst_err",   32'(err0), 32'(1'b0));
    chk("rst_ptr",   32'(u_dut0.r_ptr), 32'(3'd0));

    // First grant one cycle after request
    Resetn = 1'b1;
    Req    = 8'b00100000;
    cyc();
    chk("g2_gnt", 32'(gnt0), 32'(3'b010));
    chk("g2_oh",  32'(oh0),  32'(8'b00100000));
    chk("g2_vld", 32'(vld0), 32'(1'b1));

    // Request dropped without release: grant held
    Req = 8'b00000000;
    cyc();
    chk("hold_gnt", 32'(gnt0), 32'(3'b010));
    chk("hold_vld", 32'(vld0), 32'(1'b1));

    // Release with nothing pending: idle, Gnt keeps last value
    Rel = 1'b1;
    cyc();
    Rel = 1'b0;
    chk("idle_vld", 32'(vld0), 32'(1'b0));
    chk("idle_gnt", 32'(gnt0), 32'(3'b010));
    chk("idle_oh",  32'(oh0),  32'(8'b00000000));
    chk("idle_ptr", 32'(u_dut0.r_ptr), 32'(3'd3));

    // Release while idle: one-cycle error pulse, no state change
    Rel = 1'b1;
    cyc();
    Rel = 1'b0;
    chk("relerr_hi",  32'(err0), 32'(1'b1));
    chk("relerr_vld", 32'(vld0), 32'(1'b0));
    chk("relerr_ptr", 32'(u_dut0.r_ptr), 32'(3'd3));
    cyc();
    chk("relerr_lo",  32'(err0), 32'(1'b0));

    // R0 and R1 contending with a release every grant
    Req = 8'b11000000;
    cyc();
    chk("alt_first", 32'(gnt0), 32'(3'b000));
    chk("alt_vldf",  32'(vld0), 32'(1'b1));
    alt_exp = '{3'd1, 3'd0, 3'd1, 3'd0};
    Rel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("alt_gnt%0d", i), 32'(gnt0), 32'(alt_exp[i]));
      chk($sformatf("alt_vld%0d", i), 32'(vld0), 32'(1'b1));
    end

    // Hand over to R7, then release R7 and wrap to R0
    Req = 8'b00000001;
    cyc();
    chk("r7_gnt", 32'(gnt0), 32'(3'b111));
    chk("r7_oh",  32'(oh0),  32'(8'b00000001));
    Req = 8'b10000001;
    cyc();
    chk("wrap_gnt", 32'(gnt0), 32'(3'b000));
    chk("wrap_ptr", 32'(u_dut0.r_ptr), 32'(3'd0));
    chk("wrap_oh",  32'(oh0),  32'(8'b10000000));

    // Reset mid-grant with release asserted
    Req = 8'b00000001;
    cyc();
    chk("pre_rst_gnt", 32'(gnt0), 32'(3'b111));
    Resetn = 1'b0;
    cyc();
    chk("mrst_vld",  32'(vld0), 32'(1'b0));
    chk("mrst_gnt",  32'(gnt0), 32'(3'b000));
    chk("mrst_err",  32'(err0), 32'(1'b0));
    chk("mrst_ptr",  32'(u_dut0.r_ptr), 32'(3'd0));
    chk("mrst_vld1", 32'(vld1), 32'(1'b0));

    // Bring both instances to Ptr=2 in IDLE
    Resetn = 1'b1;
    Rel    = 1'b0;
    Req    = 8'b01000000;
    cyc();
    chk("p1_gnt0", 32'(gnt0), 32'(3'b001));
    chk("p1_gnt1", 32'(gnt1), 32'(3'b001));
    Req = 8'b00000000;
    Rel = 1'b1;
    cyc();
    Rel = 1'b0;
    chk("p2_ptr0", 32'(u_dut0.r_ptr), 32'(3'd2));
    chk("p2_ptr1", 32'(u_dut1.r_ptr), 32'(3'd2));

    // PC priority versus plain round robin on the same request
    Req = 8'b00100001;
    cyc();
    chk("rr_gnt",  32'(gnt0), 32'(3'b010));
    chk("pc_gnt",  32'(gnt1), 32'(3'b111));
    chk("pc_oh",   32'(oh1),  32'(8'b00000001));
    chk("pc_vld",  32'(vld1), 32'(1'b1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
